// File: rtl/cmp_pkg.sv
// Shared definitions for the chunked magnitude comparator stages.
// The FB_* codes are the contract between the scan stage and the LSB stage.
package cmp_pkg;

  localparam logic [1:0] FB_EQ = 2'b00;
  localparam logic [1:0] FB_GT = 2'b01;
  localparam logic [1:0] FB_LT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_chunk_encode.sv
// Unsigned compare of two chunks, encoded as a feedback code.
// Purely combinational.
module cmp_chunk_encode
  import cmp_pkg::*;
#(
  parameter int CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  output logic [1:0]         fb
);

  always_comb begin
    fb = FB_EQ;
    if (a < b) begin
      fb = FB_LT;
    end else if (a > b) begin
      fb = FB_GT;
    end
  end

endmodule

// File: rtl/comparator_s1_scan.sv
// Front stage of the chunked comparator: scans upper chunks MSB-first, one per cycle,
// stopping at the first difference; hands the feedback code plus the LSB chunks downstream.
module comparator_s1_scan
  import cmp_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CHUNK_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  A_i,
  input  logic [DATA_W-1:0]  B_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [CHUNK_W-1:0] A_lsb_o,
  output logic [CHUNK_W-1:0] B_lsb_o,
  output logic [1:0]         feedback_o
);

  localparam int N_CHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

  if ((DATA_W % CHUNK_W) != 0 || DATA_W < 2 * CHUNK_W) begin : g_bad_params
    $error("comparator_s1_scan: DATA_W must be a multiple of CHUNK_W and at least 2*CHUNK_W");
  end

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  a_reg, b_reg;
  logic [1:0]         feedback;
  logic [CHUNK_W-1:0] a_chunk, b_chunk;
  logic [1:0]         chunk_fb;
  logic               capture, step, decide;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < N_CHUNK; i++) begin
      if (idx == IDX_W'(i)) begin
        a_chunk = a_reg[i*CHUNK_W +: CHUNK_W];
        b_chunk = b_reg[i*CHUNK_W +: CHUNK_W];
      end
    end
  end

  cmp_chunk_encode #(.CHUNK_W(CHUNK_W)) u_encode (
    .a  (a_chunk),
    .b  (b_chunk),
    .fb (chunk_fb)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    step      = 1'b0;
    decide    = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid_i) begin
          capture   = 1'b1;
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        // Chunk 0 is left for the LSB stage, so idx==1 is the last chunk scanned here.
        if (chunk_fb != FB_EQ || idx == IDX_W'(1)) begin
          decide    = 1'b1;
          state_nxt = S_HOLD;
        end else begin
          step = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready_i) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      feedback <= FB_EQ;
    end else begin
      if (capture) begin
        a_reg <= A_i;
        b_reg <= B_i;
        idx   <= IDX_W'(N_CHUNK - 1);
      end
      if (step) begin
        idx <= idx - 1'b1;
      end
      if (decide) begin
        feedback <= chunk_fb;
      end
    end
  end

  assign in_ready_o  = (state == S_IDLE);
  assign out_valid_o = (state == S_HOLD);
  assign feedback_o  = feedback;
  assign A_lsb_o     = a_reg[CHUNK_W-1:0];
  assign B_lsb_o     = b_reg[CHUNK_W-1:0];

endmodule
